dual_port_ram_latencies: RTL and testbench
==========================================

// Module: dual_port_ram_latencies
// PURPOSE
//   True dual-port RAM: two independent read/write ports (A, B) on one clock.
//   Each port has its own parameterised write-commit and read-data latency.
//   Models pipelined on-chip memory, so surrounding logic can be built and
//   verified against realistic RAM timing. Depth 2**ADDR_WIDTH words.
// PARAMETERS
//   DATA_WIDTH       8  word width in bits
//   ADDR_WIDTH       3  address width; depth = 2**ADDR_WIDTH
//   WRITE_LATENCY_A  5  port A cycles from write sample to array commit (>=1)
//   READ_LATENCY_A   4  port A cycles from read sample to o_dout_a (>=1)
//   WRITE_LATENCY_B  4  port B cycles from write sample to array commit (>=1)
//   READ_LATENCY_B   5  port B cycles from read sample to o_dout_b (>=1)
// PORTS
//   i_clk     in   1           single clock, all logic on rising edge
//   i_rst     in   1           synchronous reset, active-high
//   i_en_a    in   1           port A enable
//   i_we_a    in   1           port A write enable (1=write, 0=read) when i_en_a=1
//   i_addr_a  in   ADDR_WIDTH  port A address
//   i_din_a   in   DATA_WIDTH  port A write data
//   o_dout_a  out  DATA_WIDTH  port A read data
//   i_en_b / i_we_b / i_addr_b / i_din_b / o_dout_b: same as port A, for port B
// BEHAVIOUR
//   - Request sampling: at each rising edge, port X samples {en,we,addr,din}.
//     * en=1, we=1: write request.
//     * en=1, we=0: read request.
//     * en=0: bubble, no operation.
//   - Write pipeline: a write sampled at edge N commits to the array at edge
//     N+WRITE_LATENCY_X-1. WL=1 is a classic synchronous write.
//     * The pipeline advances every cycle and accepts one request per cycle.
//     * Back-to-back writes commit back-to-back.
//   - Read pipeline: a read sampled at edge M reads the array contents as they
//     stand before edge M's commits.
//     * The data appears on o_dout_X right after edge M+READ_LATENCY_X-1.
//       RL=1 is a classic registered-output RAM.
//     * One read per cycle; back-to-back reads return data back-to-back in
//       request order.
//   - o_dout_X holds its last value on cycles where no read completes. Bubbles
//     and writes do not change it.
//   - Read vs. in-flight write: a read sees a write only if the write committed
//     at an edge strictly before the read's sampling edge. No forwarding from
//     the write pipeline, on either port.
//   - Both ports committing to the same address on the same edge: port A's
//     data wins. Different addresses both commit.
//   - A port may read while the other writes. Ports are fully independent
//     except for the shared array.
//   - Reset (i_rst=1 at an edge):
//     * Clears all write and read pipeline valid bits, so in-flight requests
//       are discarded and never commit or appear.
//     * o_dout_a = o_dout_b = 0.
//     * Array contents are unaffected.
//     * Requests are ignored while i_rst=1.
//   - Address is used as-is (full 2**ADDR_WIDTH range). No wrap or overflow
//     logic is needed.
// TESTING
//   1. A writes 0xA0,0xA1,0xA2 to addr 0,1,2 back-to-back; idle 7 cycles; A
//      reads 0,1,2 back-to-back -> o_dout_a = A0,A1,A2 on consecutive cycles,
//      the first 3 cycles after the first read edge (RL_A=4).
//   2. B writes 0xB5,0xB6 to addr 5,6; idle 6; B reads 5,6 -> o_dout_b =
//      B5 then B6, first 4 cycles after the first read edge.
//      Cross-check: A reads 5 -> B5.
//   3. Latency edge: A writes 0x3C to addr 3 at edge N.
//      -> Read sampled at edge N+3 returns the old value.
//      -> Read sampled at edge N+5 returns 0x3C.
//   4. Same edge commit: A (WL 5) write 0x11 to addr 7 at edge N; B (WL 4)
//      write 0x22 to addr 7 at edge N+1.
//      -> Both commit at N+4; a later read of addr 7 returns 0x11.
//   5. Reset mid-flight: A writes 0x55 to addr 4 (prior 0x00), i_rst pulse
//      2 cycles later.
//      -> o_dout_a/b = 0 after reset.
//      -> A read of addr 4 returns 0x00.
//   6. Hold: after a read returns 0xA2, drive en=0 for 10 cycles -> o_dout_a
//      stays 0xA2.

Source files
------------

// File: rtl/dual_port_ram_latencies.sv
// True dual-port RAM with independent, parameterised write-commit and
// read-data latencies per port; port A wins same-edge, same-address commits.

module dpr_lat_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_wire
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_reg
            logic             valid_q [STAGES];
            logic [WIDTH-1:0] data_q  [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < STAGES; i++) begin
                        valid_q[i] <= 1'b0;
                    end
                end else begin
                    valid_q[0] <= in_valid;
                    for (int unsigned i = 1; i < STAGES; i++) begin
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            // Payload needs no reset: it is only consumed when its valid bit is set.
            always_ff @(posedge clk) begin
                data_q[0] <= in_data;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end

            assign out_valid = valid_q[STAGES-1];
            assign out_data  = data_q[STAGES-1];
        end
    endgenerate

endmodule

module dual_port_ram_latencies #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH      = 3,
    parameter int unsigned WRITE_LATENCY_A = 5,
    parameter int unsigned READ_LATENCY_A  = 4,
    parameter int unsigned WRITE_LATENCY_B = 4,
    parameter int unsigned READ_LATENCY_B  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en_a,
    input  logic                  i_we_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic [DATA_WIDTH-1:0] i_din_a,
    output logic [DATA_WIDTH-1:0] o_dout_a,
    input  logic                  i_en_b,
    input  logic                  i_we_b,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    input  logic [DATA_WIDTH-1:0] i_din_b,
    output logic [DATA_WIDTH-1:0] o_dout_b
);

    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned WR_BITS = ADDR_WIDTH + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_req_a;
    logic                  rd_req_a;
    logic                  wr_req_b;
    logic                  rd_req_b;

    logic                  wr_valid_a;
    logic [WR_BITS-1:0]    wr_word_a;
    logic                  wr_valid_b;
    logic [WR_BITS-1:0]    wr_word_b;

    logic                  rd_valid_a;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic                  rd_valid_b;
    logic [DATA_WIDTH-1:0] rd_data_b;

    logic                  commit_a;
    logic                  commit_b;

    assign wr_req_a = i_en_a &  i_we_a & ~i_rst;
    assign rd_req_a = i_en_a & ~i_we_a & ~i_rst;
    assign wr_req_b = i_en_b &  i_we_b & ~i_rst;
    assign rd_req_b = i_en_b & ~i_we_b & ~i_rst;

    // A write spends WL-1 cycles in flight; the commit happens on the edge that
    // would otherwise shift it out, so WL=1 commits on the sampling edge itself.
    dpr_lat_pipe #(
        .WIDTH  (WR_BITS),
        .STAGES (WRITE_LATENCY_A - 1)
    ) u_wr_pipe_a (
        .clk       (i_clk),
        .rst       (i_rst),
        .in_valid  (wr_req_a),
        .in_data   ({i_addr_a, i_din_a}),
        .out_valid (wr_valid_a),
        .out_data  (wr_word_a)
    );

    dpr_lat_pipe #(
        .WIDTH  (WR_BITS),
        .STAGES (WRITE_LATENCY_B - 1)
    ) u_wr_pipe_b (
        .clk       (i_clk),
        .rst       (i_rst),
        .in_valid  (wr_req_b),
        .in_data   ({i_addr_b, i_din_b}),
        .out_valid (wr_valid_b),
        .out_data  (wr_word_b)
    );

    // The array is read combinationally at the sampling edge, so a read sees
    // only commits from earlier edges; the data then rides RL-1 stages.
    dpr_lat_pipe #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (READ_LATENCY_A - 1)
    ) u_rd_pipe_a (
        .clk       (i_clk),
        .rst       (i_rst),
        .in_valid  (rd_req_a),
        .in_data   (mem[i_addr_a]),
        .out_valid (rd_valid_a),
        .out_data  (rd_data_a)
    );

    dpr_lat_pipe #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (READ_LATENCY_B - 1)
    ) u_rd_pipe_b (
        .clk       (i_clk),
        .rst       (i_rst),
        .in_valid  (rd_req_b),
        .in_data   (mem[i_addr_b]),
        .out_valid (rd_valid_b),
        .out_data  (rd_data_b)
    );

    assign commit_a = wr_valid_a & ~i_rst;
    assign commit_b = wr_valid_b & ~i_rst;

    // Port A is assigned last so it wins a same-address collision.
    always_ff @(posedge i_clk) begin
        if (commit_b) begin
            mem[wr_word_b[WR_BITS-1:DATA_WIDTH]] <= wr_word_b[DATA_WIDTH-1:0];
        end
        if (commit_a) begin
            mem[wr_word_a[WR_BITS-1:DATA_WIDTH]] <= wr_word_a[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dout_a <= '0;
            o_dout_b <= '0;
        end else begin
            if (rd_valid_a) begin
                o_dout_a <= rd_data_a;
            end
            if (rd_valid_b) begin
                o_dout_b <= rd_data_b;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_ram_latencies.sv
// Directed bench for dual_port_ram_latencies: one table row per clock edge
// with hand-computed outputs, plus a hand-written reset-mid-flight sequence.

module tb_dual_port_ram_latencies;

    typedef struct {
        logic       en_a;
        logic       we_a;
        logic [2:0] addr_a;
        logic [7:0] din_a;
        logic       en_b;
        logic       we_b;
        logic [2:0] addr_b;
        logic [7:0] din_b;
        logic       chk_a;
        logic [7:0] exp_a;
        logic       chk_b;
        logic [7:0] exp_b;
    } vec_t;

    localparam int NROWS = 63;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, we_a, en_b, we_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] din_a, din_b;
    logic [7:0] dout_a, dout_b;

    int checks = 0;
    int errors = 0;

    vec_t vecs [NROWS];

    dual_port_ram_latencies #(
        .DATA_WIDTH      (8),
        .ADDR_WIDTH      (3),
        .WRITE_LATENCY_A (5),
        .READ_LATENCY_A  (4),
        .WRITE_LATENCY_B (4),
        .READ_LATENCY_B  (5)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en_a   (en_a),
        .i_we_a   (we_a),
        .i_addr_a (addr_a),
        .i_din_a  (din_a),
        .o_dout_a (dout_a),
        .i_en_b   (en_b),
        .i_we_b   (we_b),
        .i_addr_b (addr_b),
        .i_din_b  (din_b),
        .o_dout_b (dout_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r,
                         input logic ea, input logic wa, input logic [2:0] aa, input logic [7:0] da,
                         input logic eb, input logic wb, input logic [2:0] ab, input logic [7:0] db);
        rst = r;
        en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic set_a(input int r, input logic w, input logic [2:0] a, input logic [7:0] d);
        vecs[r].en_a = 1'b1; vecs[r].we_a = w; vecs[r].addr_a = a; vecs[r].din_a = d;
    endtask

    task automatic set_b(input int r, input logic w, input logic [2:0] a, input logic [7:0] d);
        vecs[r].en_b = 1'b1; vecs[r].we_b = w; vecs[r].addr_b = a; vecs[r].din_b = d;
    endtask

    task automatic want_a(input int r, input logic [7:0] v);
        vecs[r].chk_a = 1'b1; vecs[r].exp_a = v;
    endtask

    task automatic want_b(input int r, input logic [7:0] v);
        vecs[r].chk_b = 1'b1; vecs[r].exp_b = v;
    endtask

    initial begin
        for (int r = 0; r < NROWS; r++) begin
            vecs[r] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00,
                        1'b0, 8'h00, 1'b0, 8'h00};
        end
        // Clear the array through port A (commits at rows 4..11).
        for (int r = 0; r < 8; r++) set_a(r, 1'b1, 3'(r), 8'h00);
        // Back-to-back writes on both ports, then reads after the idle gap.
        set_a(12, 1'b1, 3'd0, 8'hA0); set_a(13, 1'b1, 3'd1, 8'hA1); set_a(14, 1'b1, 3'd2, 8'hA2);
        set_b(12, 1'b1, 3'd5, 8'hB5); set_b(13, 1'b1, 3'd6, 8'hB6);
        set_b(20, 1'b0, 3'd5, 8'h00); set_b(21, 1'b0, 3'd6, 8'h00);
        set_a(22, 1'b0, 3'd0, 8'h00); set_a(23, 1'b0, 3'd1, 8'h00); set_a(24, 1'b0, 3'd2, 8'h00);
        want_b(23, 8'h00); want_b(24, 8'hB5); want_b(25, 8'hB6);
        want_a(24, 8'h00); want_a(25, 8'hA0); want_a(26, 8'hA1); want_a(27, 8'hA2);
        // Hold across ten bubbles, then cross-port read of B's data.
        want_a(30, 8'hA2); want_b(30, 8'hB6); want_a(37, 8'hA2);
        set_a(35, 1'b0, 3'd5, 8'h00);
        want_a(38, 8'hB5);
        // Write at 40 commits at 44: reads at 43 and 44 see old, 45 sees new.
        set_a(40, 1'b1, 3'd3, 8'h3C);
        set_a(43, 1'b0, 3'd3, 8'h00); set_a(44, 1'b0, 3'd3, 8'h00); set_a(45, 1'b0, 3'd3, 8'h00);
        want_a(45, 8'hB5); want_a(46, 8'h00); want_a(47, 8'h00); want_a(48, 8'h3C);
        // Same-edge commits at 54 (same address) and 56 (different addresses).
        set_a(50, 1'b1, 3'd7, 8'h11); set_b(51, 1'b1, 3'd7, 8'h22);
        set_a(52, 1'b1, 3'd6, 8'h66); set_b(53, 1'b1, 3'd1, 8'h77);
        set_a(57, 1'b0, 3'd7, 8'h00); set_b(57, 1'b0, 3'd6, 8'h00);
        set_a(58, 1'b0, 3'd1, 8'h00); set_b(58, 1'b0, 3'd7, 8'h00);
        want_a(59, 8'h3C); want_a(60, 8'h11); want_b(60, 8'hB6);
        want_a(61, 8'h77); want_b(61, 8'h66);
        want_a(62, 8'h77); want_b(62, 8'h11);

        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        check("reset dout_a", dout_a, 8'h00);
        check("reset dout_b", dout_b, 8'h00);

        for (int r = 0; r < NROWS; r++) begin
            drive(1'b0, vecs[r].en_a, vecs[r].we_a, vecs[r].addr_a, vecs[r].din_a,
                  vecs[r].en_b, vecs[r].we_b, vecs[r].addr_b, vecs[r].din_b);
            if (vecs[r].chk_a) check($sformatf("row%0d dout_a", r), dout_a, vecs[r].exp_a);
            if (vecs[r].chk_b) check($sformatf("row%0d dout_b", r), dout_b, vecs[r].exp_b);
        end

        // Reset mid-flight: pending write of 0x55 and pending B read are dropped,
        // and requests presented during reset are ignored.
        drive(1'b0, 1'b1, 1'b1, 3'd4, 8'h55, 1'b1, 1'b0, 3'd5, 8'h00);
        idle(1);
        drive(1'b1, 1'b1, 1'b1, 3'd4, 8'h99, 1'b1, 1'b1, 3'd4, 8'hEE);
        check("midreset dout_a", dout_a, 8'h00);
        check("midreset dout_b", dout_b, 8'h00);
        idle(6);
        check("postreset dout_a", dout_a, 8'h00);
        check("postreset dout_b", dout_b, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00);
        idle(1);
        check("rst read0 dout_a", dout_a, 8'h00);
        idle(1);
        check("rst read0 dout_a", dout_a, 8'hA0);
        idle(1);
        check("rst read4 dout_a", dout_a, 8'h00);
        check("rst read0 dout_b", dout_b, 8'hA0);
        idle(1);
        check("rst read4 dout_b", dout_b, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
